instr_loader: RTL

Byte-stream program loader that fills the core's instruction memory before execution. It accepts a length-prefixed stream of bytes from the board's serial receive path and assembles them into little-endian 32-bit instructions. It writes each instruction to sequential instruction-memory addresses through a valid/ready write port. While loading, it holds the fetch/scheduling logic frozen; it releases the core once the program is complete. It is the writer counterpart to the instruction cache that reads this memory.

---
 rtl/loader_pkg.sv | 15 +
 rtl/instr_loader_if.sv | 25 ++
 rtl/word_assembler.sv | 46 ++++
 rtl/instr_loader.sv | 125 ++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and defaults for the instruction-memory program loader.
package loader_pkg;

   localparam int DEPTH_DEFAULT = 64;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      BYTE,
      WRITE,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Byte receive stream plus instruction-memory write port of the program loader.
interface instr_loader_if import loader_pkg::*; #(
   parameter int ADDR_W = $clog2(DEPTH_DEFAULT)
);

   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              wr_ready;

   // The loader is the master: it consumes the byte stream and issues writes.
   modport master (
      input  rx_valid, rx_data, wr_ready,
      output rx_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      output rx_valid, rx_data, wr_ready,
      input  rx_ready, wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/word_assembler.sv
// Packs four consecutive bytes into a little-endian 32-bit word.
module word_assembler (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_full
);

   logic [1:0]  lane_q, lane_d;
   logic [31:0] word_q, word_d;

   always_comb begin
      lane_d = lane_q;
      word_d = word_q;
      if (clear) begin
         lane_d = 2'd0;
         word_d = 32'h0;
      end else if (byte_valid) begin
         case (lane_q)
            2'd0:    word_d[7:0]   = byte_in;
            2'd1:    word_d[15:8]  = byte_in;
            2'd2:    word_d[23:16] = byte_in;
            default: word_d[31:24] = byte_in;
         endcase
         lane_d = lane_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane_q <= 2'd0;
         word_q <= 32'h0;
      end else begin
         lane_q <= lane_d;
         word_q <= word_d;
      end
   end

   // Asserted on the cycle the last lane is being captured; the word is complete next cycle.
   assign word_full = byte_valid & ~clear & (lane_q == 2'd3);
   assign word      = word_q;

endmodule

// File: rtl/instr_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding the core.
module instr_loader import loader_pkg::*; #(
   parameter int DEPTH  = DEPTH_DEFAULT,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   instr_loader_if.master  bus,
   output logic            core_hold,
   output logic            loading,
   output logic            done,
   output logic            overflow,
   output logic [ADDR_W:0] word_count
);

   state_t            state_q, state_d;
   logic              start_q;
   logic [7:0]        n_q, n_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   word_count_q, word_count_d;
   logic [ADDR_W:0]   count_inc;
   logic              start_edge;
   logic              asm_clear;
   logic              asm_valid;
   logic              asm_full;
   logic [31:0]       asm_word;

   assign start_edge = start & ~start_q;
   assign count_inc  = word_count_q + 1'b1;
   assign asm_clear  = (state_q == HDR);
   assign asm_valid  = (state_q == BYTE) & bus.rx_valid;

   word_assembler u_asm (
      .clk       (clk),
      .rst       (rst),
      .clear     (asm_clear),
      .byte_valid(asm_valid),
      .byte_in   (bus.rx_data),
      .word      (asm_word),
      .word_full (asm_full)
   );

   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      addr_d       = addr_q;
      word_count_d = word_count_q;
      bus.rx_ready = 1'b0;
      bus.wr_en    = 1'b0;
      bus.wr_addr  = addr_q;
      bus.wr_data  = asm_word;
      core_hold    = 1'b0;
      loading      = 1'b0;
      done         = 1'b0;
      overflow     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_edge) state_d = HDR;
         end
         HDR: begin
            bus.rx_ready = 1'b1;
            core_hold    = 1'b1;
            loading      = 1'b1;
            if (bus.rx_valid) begin
               n_d          = bus.rx_data;
               word_count_d = '0;
               addr_d       = '0;
               if (bus.rx_data == 8'd0)              state_d = DONE;
               else if (32'(bus.rx_data) > DEPTH)    state_d = ERR;
               else                                  state_d = BYTE;
            end
         end
         BYTE: begin
            bus.rx_ready = 1'b1;
            core_hold    = 1'b1;
            loading      = 1'b1;
            if (asm_full) state_d = WRITE;
         end
         WRITE: begin
            bus.wr_en = 1'b1;
            core_hold = 1'b1;
            loading   = 1'b1;
            // The address is not advanced past the final word so it never wraps.
            if (bus.wr_ready) begin
               word_count_d = count_inc;
               if (8'(count_inc) == n_q) begin
                  state_d = DONE;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = BYTE;
               end
            end
         end
         DONE: begin
            done = 1'b1;
            if (start_edge) state_d = HDR;
         end
         ERR: begin
            overflow = 1'b1;
            if (start_edge) state_d = HDR;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         start_q      <= 1'b0;
         n_q          <= 8'd0;
         addr_q       <= '0;
         word_count_q <= '0;
      end else begin
         state_q      <= state_d;
         start_q      <= start;
         n_q          <= n_d;
         addr_q       <= addr_d;
         word_count_q <= word_count_d;
      end
   end

   assign word_count = word_count_q;

endmodule
